// File: rtl/ieee1500_param_wrapper.sv
// ---------------------------------------------------------------------------
// ieee1500_param_wrapper
//
// Parameterised IEEE 1500 style core test wrapper: a wrapper instruction
// register (WIR), a wrapper boundary register (WBR) with update stage and a
// one-bit wrapper bypass register (WBY). Shift-length checking is provided
// through shift_cnt / len_err.
//
// Optional feature: define WRAPPER_SAFE_EN to decode opcode 5 as SAFE
// (core_in forced to 0, pin_out forced to SAFE_VALUE). Without the macro,
// opcode 5 behaves as BYPASS and SAFE_VALUE has no effect.
//
// Ports:
//   wrck                    wrapper clock (only clock)
//   wrst                    synchronous active-high reset
//   wsi / wso               wrapper serial in / out (wso is combinational)
//   selectwir               1 = WIR scan, 0 = WDR scan
//   capturewir/shiftwir/updatewir   WIR scan controls
//   capturewdr/shiftwdr/updatewdr   WDR scan controls
//   pin_in  [NUM_IN]        SoC-side functional inputs
//   core_in [NUM_IN]        inputs driven to the core
//   core_out[NUM_OUT]       core functional outputs
//   pin_out [NUM_OUT]       SoC-side functional outputs
//   wir_q   [WIR_WIDTH]     active instruction
//   shift_cnt[16]           WDR shift cycles since last capturewdr (saturating)
//   len_err                 WDR scan-length mismatch, loaded on updatewdr
// ---------------------------------------------------------------------------
module ieee1500_param_wrapper #(
    parameter int                 NUM_IN     = 8,
    parameter int                 NUM_OUT    = 8,
    parameter int                 WIR_WIDTH  = 3,
    parameter logic [NUM_OUT-1:0] SAFE_VALUE = '0
) (
    input  logic                 wrck,
    input  logic                 wrst,
    input  logic                 wsi,
    output logic                 wso,
    input  logic                 selectwir,
    input  logic                 capturewir,
    input  logic                 shiftwir,
    input  logic                 updatewir,
    input  logic                 capturewdr,
    input  logic                 shiftwdr,
    input  logic                 updatewdr,
    input  logic [NUM_IN-1:0]    pin_in,
    output logic [NUM_IN-1:0]    core_in,
    input  logic [NUM_OUT-1:0]   core_out,
    output logic [NUM_OUT-1:0]   pin_out,
    output logic [WIR_WIDTH-1:0] wir_q,
    output logic [15:0]          shift_cnt,
    output logic                 len_err
);

    localparam int WBR_LEN = NUM_IN + NUM_OUT;

    localparam logic [WIR_WIDTH-1:0] OP_EXTEST = WIR_WIDTH'(1);
    localparam logic [WIR_WIDTH-1:0] OP_INTEST = WIR_WIDTH'(2);
    localparam logic [WIR_WIDTH-1:0] OP_SAMPLE = WIR_WIDTH'(3);
    localparam logic [WIR_WIDTH-1:0] OP_CLAMP  = WIR_WIDTH'(4);
`ifdef WRAPPER_SAFE_EN
    localparam logic [WIR_WIDTH-1:0] OP_SAFE   = WIR_WIDTH'(5);
`endif
    // Value parked in the WIR shift stage on capturewir.
    localparam logic [WIR_WIDTH-1:0] WIR_CAPTURE = WIR_WIDTH'(2'b01);
    localparam logic [15:0]          WBR_LEN16   = 16'(WBR_LEN);

    typedef enum logic [2:0] {
        INS_BYPASS = 3'd0,
        INS_EXTEST = 3'd1,
        INS_INTEST = 3'd2,
        INS_SAMPLE = 3'd3,
        INS_CLAMP  = 3'd4,
        INS_SAFE   = 3'd5
    } instr_e;

    instr_e               instr;
    logic                 wbr_sel;   // WBR is the selected WDR (else WBY)
    logic                 cap_in;    // in_cells capture pin_in
    logic                 cap_out;   // out_cells capture core_out
    logic                 safe_sel;

    logic [WIR_WIDTH-1:0] wir_shift_q, wir_shift_d;
    logic [WIR_WIDTH-1:0] wir_d;
    // Chain layout: [WBR_LEN-1:NUM_OUT] = in_cells, [NUM_OUT-1:0] = out_cells.
    logic [WBR_LEN-1:0]   wbr_q, wbr_d;
    logic [NUM_IN-1:0]    upd_in_q, upd_in_d;
    logic [NUM_OUT-1:0]   upd_out_q, upd_out_d;
    logic                 wby_q, wby_d;
    logic [15:0]          shift_cnt_q, shift_cnt_d;
    logic                 len_err_q, len_err_d;

    // ---------------- instruction decode ----------------
    always_comb begin
        instr = INS_BYPASS;
        case (wir_q)
            OP_EXTEST: instr = INS_EXTEST;
            OP_INTEST: instr = INS_INTEST;
            OP_SAMPLE: instr = INS_SAMPLE;
            OP_CLAMP:  instr = INS_CLAMP;
`ifdef WRAPPER_SAFE_EN
            OP_SAFE:   instr = INS_SAFE;
`endif
            default:   instr = INS_BYPASS;
        endcase
    end

    assign wbr_sel = (instr == INS_EXTEST) || (instr == INS_INTEST) || (instr == INS_SAMPLE);
    assign cap_in  = (instr == INS_EXTEST) || (instr == INS_SAMPLE);
    assign cap_out = (instr == INS_INTEST) || (instr == INS_SAMPLE);
    assign safe_sel = (instr == INS_SAFE);

    // ---------------- next-state logic ----------------
    always_comb begin
        wir_shift_d = wir_shift_q;
        wir_d       = wir_q;
        wbr_d       = wbr_q;
        upd_in_d    = upd_in_q;
        upd_out_d   = upd_out_q;
        wby_d       = wby_q;
        shift_cnt_d = shift_cnt_q;
        len_err_d   = len_err_q;

        if (selectwir) begin
            if (capturewir) begin
                wir_shift_d = WIR_CAPTURE;
            end else if (shiftwir) begin
                wir_shift_d = {wsi, wir_shift_q[WIR_WIDTH-1:1]};
            end
            // Update sees the pre-edge shift stage, independent of capture/shift.
            if (updatewir) begin
                wir_d = wir_shift_q;
            end
        end else begin
            if (capturewdr) begin
                shift_cnt_d = '0;
                if (wbr_sel) begin
                    if (cap_in)  wbr_d[WBR_LEN-1:NUM_OUT] = pin_in;
                    if (cap_out) wbr_d[NUM_OUT-1:0]       = core_out;
                end else begin
                    wby_d = 1'b0;
                end
            end else if (shiftwdr) begin
                if (shift_cnt_q != 16'hFFFF) begin
                    shift_cnt_d = shift_cnt_q + 16'd1;
                end
                if (wbr_sel) begin
                    wbr_d = {wsi, wbr_q[WBR_LEN-1:1]};
                end else begin
                    wby_d = wsi;
                end
            end
            if (updatewdr) begin
                len_err_d = wbr_sel ? (shift_cnt_q != WBR_LEN16) : (shift_cnt_q != 16'd1);
                // CLAMP/SAFE/BYPASS keep the update stage frozen.
                if (wbr_sel) begin
                    upd_in_d  = wbr_q[WBR_LEN-1:NUM_OUT];
                    upd_out_d = wbr_q[NUM_OUT-1:0];
                end
            end
        end
    end

    // ---------------- state registers ----------------
    always_ff @(posedge wrck) begin
        if (wrst) begin
            wir_shift_q <= '0;
            wir_q       <= '0;
            wbr_q       <= '0;
            upd_in_q    <= '0;
            upd_out_q   <= '0;
            wby_q       <= 1'b0;
            shift_cnt_q <= '0;
            len_err_q   <= 1'b0;
        end else begin
            wir_shift_q <= wir_shift_d;
            wir_q       <= wir_d;
            wbr_q       <= wbr_d;
            upd_in_q    <= upd_in_d;
            upd_out_q   <= upd_out_d;
            wby_q       <= wby_d;
            shift_cnt_q <= shift_cnt_d;
            len_err_q   <= len_err_d;
        end
    end

    // ---------------- outputs ----------------
    always_comb begin
        wso = 1'b0;
        if (selectwir && shiftwir) begin
            wso = wir_shift_q[0];
        end else if (!selectwir && shiftwdr) begin
            wso = wbr_sel ? wbr_q[0] : wby_q;
        end
    end

    always_comb begin
        core_in = pin_in;
        pin_out = core_out;
        case (instr)
            INS_EXTEST: pin_out = upd_out_q;
            INS_INTEST: begin
                core_in = upd_in_q;
                pin_out = upd_out_q;
            end
            INS_CLAMP:  pin_out = upd_out_q;
            default:    ;
        endcase
        if (safe_sel) begin
            core_in = '0;
            pin_out = SAFE_VALUE;
        end
    end

    assign shift_cnt = shift_cnt_q;
    assign len_err   = len_err_q;

endmodule

// File: tb/tb_ieee1500_param_wrapper.sv
module tb_ieee1500_param_wrapper;

  localparam int NI = 8;
  localparam int NO = 8;
  localparam int WW = 3;

  logic          wrck = 1'b0;
  logic          wrst;
  logic          wsi;
  logic          wso;
  logic          selectwir, capturewir, shiftwir, updatewir;
  logic          capturewdr, shiftwdr, updatewdr;
  logic [NI-1:0] pin_in;
  logic [NI-1:0] core_in;
  logic [NO-1:0] core_out;
  logic [NO-1:0] pin_out;
  logic [WW-1:0] wir_q;
  logic [15:0]   shift_cnt;
  logic          len_err;

  int checks = 0;
  int failures = 0;
  logic [0:0] exp_q[$];

  // ---------------- clock/reset block ----------------
  always #5 wrck = ~wrck;

  initial begin
    #200000;
    $display("FAIL timeout: run did not finish (got running, need done)");
    $fatal(1, "timeout");
  end

  ieee1500_param_wrapper #(
    .NUM_IN(NI), .NUM_OUT(NO), .WIR_WIDTH(WW), .SAFE_VALUE(8'hC3)
  ) dut (
    .wrck(wrck), .wrst(wrst), .wsi(wsi), .wso(wso),
    .selectwir(selectwir), .capturewir(capturewir), .shiftwir(shiftwir), .updatewir(updatewir),
    .capturewdr(capturewdr), .shiftwdr(shiftwdr), .updatewdr(updatewdr),
    .pin_in(pin_in), .core_in(core_in), .core_out(core_out), .pin_out(pin_out),
    .wir_q(wir_q), .shift_cnt(shift_cnt), .len_err(len_err)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge wrck);
    #1;
  endtask

  task automatic idle();
    selectwir  = 1'b0;
    capturewir = 1'b0;
    shiftwir   = 1'b0;
    updatewir  = 1'b0;
    capturewdr = 1'b0;
    shiftwdr   = 1'b0;
    updatewdr  = 1'b0;
    wsi        = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // WIR scan: capture, shift opcode LSB first, update. Checks wso per shift.
  task automatic load_wir(input logic [2:0] op);
    logic [2:0] m;
    idle();
    selectwir  = 1'b1;
    capturewir = 1'b1;
    tick();
    capturewir = 1'b0;
    shiftwir   = 1'b1;
    m = 3'b001;
    for (int i = 0; i < 3; i++) begin
      wsi = op[i];
      exp_q.push_back(m[0]);
      m = {op[i], m[2:1]};
      #1;
      check($sformatf("wir_wso[%0d] op%0d", i, op), {31'd0, wso}, {31'd0, exp_q.pop_front()});
      tick();
    end
    shiftwir  = 1'b0;
    updatewir = 1'b1;
    tick();
    idle();
    check($sformatf("wir_q op%0d", op), {29'd0, wir_q}, {29'd0, op});
  endtask

  // WDR scan: capture, n shifts of din (LSB first) checking wso against exp_wso.
  task automatic wdr_scan(input int n, input logic [15:0] din, input logic [15:0] exp_wso,
                          input bit do_update);
    idle();
    capturewdr = 1'b1;
    tick();
    capturewdr = 1'b0;
    shiftwdr   = 1'b1;
    for (int i = 0; i < n; i++) begin
      wsi = din[i];
      exp_q.push_back(exp_wso[i]);
      #1;
      check($sformatf("wdr_wso[%0d]", i), {31'd0, wso}, {31'd0, exp_q.pop_front()});
      tick();
    end
    shiftwdr = 1'b0;
    wsi      = 1'b0;
    if (do_update) begin
      updatewdr = 1'b1;
      tick();
      updatewdr = 1'b0;
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    idle();
    wrst     = 1'b1;
    pin_in   = 8'h3E;
    core_out = 8'h81;
    tick();
    tick();
    wrst = 1'b0;
    #1;
    check("rst_wir_q", {29'd0, wir_q}, 32'd0);
    check("rst_shift_cnt", {16'd0, shift_cnt}, 32'd0);
    check("rst_len_err", {31'd0, len_err}, 32'd0);
    check("rst_wso", {31'd0, wso}, 32'd0);
    check("rst_core_in", {24'd0, core_in}, 32'h3E);
    check("rst_pin_out", {24'd0, pin_out}, 32'h81);

    // EXTEST: wso 1,0,0 during the WIR shifts
    load_wir(3'd1);
    pin_in = 8'hA5;
    #1;
    check("extest_pin_out_pre", {24'd0, pin_out}, 32'h00);
    wdr_scan(16, 16'h003C, 16'hA500, 1'b1);
    #1;
    check("extest_pin_out", {24'd0, pin_out}, 32'h3C);
    check("extest_core_in", {24'd0, core_in}, 32'hA5);
    check("extest_len_err", {31'd0, len_err}, 32'd0);
    check("extest_shift_cnt", {16'd0, shift_cnt}, 32'd16);

    // Load upd_in = 12 (out cells hold 3C across the EXTEST capture)
    wdr_scan(16, 16'h123C, 16'hA53C, 1'b1);
    #1;
    check("extest2_pin_out", {24'd0, pin_out}, 32'h3C);

    // INTEST
    load_wir(3'd2);
    core_out = 8'h77;
    #1;
    check("intest_core_in_pre", {24'd0, core_in}, 32'h12);
    check("intest_pin_out_pre", {24'd0, pin_out}, 32'h3C);
    wdr_scan(16, 16'h0000, 16'h1277, 1'b0);
    check("intest_core_in_scan", {24'd0, core_in}, 32'h12);
    updatewdr = 1'b1;
    tick();
    updatewdr = 1'b0;
    check("intest_core_in_upd", {24'd0, core_in}, 32'h00);
    check("intest_pin_out_upd", {24'd0, pin_out}, 32'h00);
    check("intest_len_err", {31'd0, len_err}, 32'd0);

    // SAMPLE
    load_wir(3'd3);
    pin_in   = 8'h5A;
    core_out = 8'hC6;
    #1;
    check("sample_core_in", {24'd0, core_in}, 32'h5A);
    check("sample_pin_out", {24'd0, pin_out}, 32'hC6);
    wdr_scan(16, 16'hBEEF, 16'h5AC6, 1'b1);
    check("sample_pin_out_post", {24'd0, pin_out}, 32'hC6);

    // CLAMP: drives upd_out, update stage frozen, WBY selected
    load_wir(3'd4);
    check("clamp_pin_out", {24'd0, pin_out}, 32'hEF);
    check("clamp_core_in", {24'd0, core_in}, 32'h5A);
    wdr_scan(1, 16'h0001, 16'h0000, 1'b1);
    check("clamp_pin_out_hold", {24'd0, pin_out}, 32'hEF);
    check("clamp_len_err", {31'd0, len_err}, 32'd0);

    // Opcode 5
    load_wir(3'd5);
`ifdef WRAPPER_SAFE_EN
    check("safe_pin_out", {24'd0, pin_out}, 32'hC3);
    check("safe_core_in", {24'd0, core_in}, 32'h00);
`else
    check("op5_pin_out", {24'd0, pin_out}, 32'hC6);
    check("op5_core_in", {24'd0, core_in}, 32'h5A);
`endif

    // Unused opcode acts as BYPASS
    load_wir(3'd7);
    check("op7_pin_out", {24'd0, pin_out}, 32'hC6);
    check("op7_core_in", {24'd0, core_in}, 32'h5A);

    // BYPASS length checks
    load_wir(3'd0);
    wdr_scan(1, 16'h0001, 16'h0000, 1'b1);
    check("bypass1_len_err", {31'd0, len_err}, 32'd0);
    wdr_scan(2, 16'h0001, 16'h0002, 1'b1);
    check("bypass2_len_err", {31'd0, len_err}, 32'd1);
    check("bypass2_shift_cnt", {16'd0, shift_cnt}, 32'd2);

    // Reset in the middle of an EXTEST WBR scan
    load_wir(3'd1);
    pin_in   = 8'hA5;
    core_out = 8'h77;
    capturewdr = 1'b1;
    tick();
    capturewdr = 1'b0;
    shiftwdr   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wsi = i[0];
      tick();
    end
    check("midscan_shift_cnt", {16'd0, shift_cnt}, 32'd5);
    wrst = 1'b1;
    tick();
    wrst = 1'b0;
    idle();
    #1;
    check("mrst_wir_q", {29'd0, wir_q}, 32'd0);
    check("mrst_core_in", {24'd0, core_in}, 32'hA5);
    check("mrst_pin_out", {24'd0, pin_out}, 32'h77);
    check("mrst_wso", {31'd0, wso}, 32'd0);
    check("mrst_shift_cnt", {16'd0, shift_cnt}, 32'd0);
    check("mrst_len_err", {31'd0, len_err}, 32'd0);
    // Update stage was cleared too: EXTEST now drives zeros.
    load_wir(3'd1);
    check("mrst_upd_out", {24'd0, pin_out}, 32'h00);

    // ---------------- final report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
